// File: rtl/decoder_8b10b_sync_ctrl_if.sv
// rtl/decoder_8b10b_sync_ctrl_if.sv - raw symbol, decoder and decoded-stream signals of the sync controller
interface decoder_8b10b_sync_ctrl_if #(
  parameter int ERR_W = 3
);
  logic             sym_valid;
  logic [9:0]       sym_dat;

  logic             dec_din_ena;
  logic [9:0]       dec_din_dat;
  logic             dec_din_rd;
  logic             dec_dout_val;
  logic [7:0]       dec_dout_dat;
  logic             dec_dout_k;
  logic             dec_dout_kerr;
  logic             dec_dout_rderr;
  logic             dec_dout_rdcomb;

  logic             bitslip;
  logic             out_val;
  logic [7:0]       out_dat;
  logic             out_k;
  logic             out_err;
  logic             link_locked;
  logic [1:0]       link_state;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    input  sym_valid, sym_dat,
    input  dec_dout_val, dec_dout_dat, dec_dout_k, dec_dout_kerr, dec_dout_rderr, dec_dout_rdcomb,
    output dec_din_ena, dec_din_dat, dec_din_rd,
    output bitslip, out_val, out_dat, out_k, out_err, link_locked, link_state, err_cnt
  );

  modport slave (
    output sym_valid, sym_dat,
    output dec_dout_val, dec_dout_dat, dec_dout_k, dec_dout_kerr, dec_dout_rderr, dec_dout_rdcomb,
    input  dec_din_ena, dec_din_dat, dec_din_rd,
    input  bitslip, out_val, out_dat, out_k, out_err, link_locked, link_state, err_cnt
  );
endinterface

// File: rtl/decoder_8b10b_sync_ctrl.sv
// rtl/decoder_8b10b_sync_ctrl.sv - comma hunt, bitslip, word lock and error tracking around an 8b10b decoder
module decoder_8b10b_sync_ctrl #(
  parameter int LOCK_COMMAS = 4,
  parameter int ERR_LIMIT   = 4,
  parameter int GOOD_RUN    = 16,
  parameter int SLIP_WINDOW = 64,
  parameter int SLIP_HOLD   = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  decoder_8b10b_sync_ctrl_if.master bus
);
  localparam int ERR_W   = $clog2(ERR_LIMIT + 1);
  localparam int COMMA_W = $clog2(LOCK_COMMAS + 1);
  localparam int GOOD_W  = $clog2(GOOD_RUN + 1);
  localparam int SLIP_W  = $clog2(SLIP_WINDOW + 1);
  localparam int HOLD_W  = $clog2(SLIP_HOLD + 1);

  localparam logic [9:0]         K28_5_NEG  = 10'h17C;
  localparam logic [9:0]         K28_5_POS  = 10'h283;
  localparam logic [7:0]         K28_5_BYTE = 8'hBC;
  localparam logic [ERR_W-1:0]   ERR_MAX    = ERR_W'(ERR_LIMIT);
  localparam logic [COMMA_W-1:0] COMMA_LAST = COMMA_W'(LOCK_COMMAS - 1);
  localparam logic [COMMA_W-1:0] COMMA_FULL = COMMA_W'(LOCK_COMMAS);
  localparam logic [GOOD_W-1:0]  GOOD_LAST  = GOOD_W'(GOOD_RUN - 1);
  localparam logic [SLIP_W-1:0]  SLIP_LAST  = SLIP_W'(SLIP_WINDOW - 1);
  localparam logic [SLIP_W-1:0]  SLIP_FULL  = SLIP_W'(SLIP_WINDOW);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(SLIP_HOLD - 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2,
    SLIP   = 2'd3
  } state_e;

  state_e             state_q;
  logic               din_ena_q;
  logic [9:0]         din_dat_q;
  logic               tag1_q;
  logic               tag2_q;
  logic               rd_q;
  logic               rd_d;
  logic [COMMA_W-1:0] comma_cnt_q;
  logic [SLIP_W-1:0]  slip_cnt_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [GOOD_W-1:0]  good_cnt_q;
  logic [ERR_W-1:0]   err_cnt_q;
  logic               bitslip_q;
  logic               out_val_q;
  logic [7:0]         out_dat_q;
  logic               out_k_q;
  logic               out_err_q;

  logic comma_raw;
  logic sym_take;
  logic dec_fire;
  logic dec_err;
  logic comma_dec;
  logic err_full;

  assign comma_raw = (bus.sym_dat == K28_5_NEG) || (bus.sym_dat == K28_5_POS);
  assign sym_take  = bus.sym_valid && (state_q != SLIP);
  // Only results whose tag travelled alongside them through the decoder steer the FSM.
  assign dec_fire  = bus.dec_dout_val && tag2_q;
  assign dec_err   = bus.dec_dout_kerr | bus.dec_dout_rderr;
  assign comma_dec = bus.dec_dout_k && (bus.dec_dout_dat == K28_5_BYTE);
  assign err_full  = (err_cnt_q == ERR_MAX);

  // A raw comma in HUNT seeds the disparity the decoder should expect; afterwards the decoder tracks it.
  always_comb begin
    rd_d = rd_q;
    if (state_q == HUNT) begin
      if (sym_take && comma_raw) begin
        rd_d = (bus.sym_dat == K28_5_NEG);
      end
    end else if ((state_q == CHECK || state_q == LOCKED) && din_ena_q) begin
      rd_d = bus.dec_dout_rdcomb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_ena_q <= 1'b0;
      din_dat_q <= '0;
      tag1_q    <= 1'b0;
      tag2_q    <= 1'b0;
      rd_q      <= 1'b0;
    end else begin
      din_ena_q <= sym_take;
      if (sym_take) begin
        din_dat_q <= bus.sym_dat;
        tag1_q    <= (state_q != HUNT) | comma_raw;
      end
      tag2_q <= din_ena_q & tag1_q;
      rd_q   <= rd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      comma_cnt_q <= '0;
      slip_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
      bitslip_q   <= 1'b0;
      out_val_q   <= 1'b0;
      out_dat_q   <= '0;
      out_k_q     <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      out_val_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (bus.sym_valid) begin
            if (comma_raw) begin
              state_q     <= CHECK;
              comma_cnt_q <= '0;
              slip_cnt_q  <= '0;
            end else if (slip_cnt_q == SLIP_LAST) begin
              state_q    <= SLIP;
              bitslip_q  <= 1'b1;
              hold_cnt_q <= '0;
              slip_cnt_q <= SLIP_FULL;
            end else begin
              slip_cnt_q <= slip_cnt_q + 1'b1;
            end
          end
        end
        SLIP: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= HUNT;
            hold_cnt_q <= '0;
            slip_cnt_q <= '0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (dec_fire) begin
            if (dec_err) begin
              state_q <= HUNT;
            end else if (comma_dec) begin
              if (comma_cnt_q == COMMA_LAST) begin
                state_q     <= LOCKED;
                comma_cnt_q <= COMMA_FULL;
                err_cnt_q   <= '0;
                good_cnt_q  <= '0;
              end else begin
                comma_cnt_q <= comma_cnt_q + 1'b1;
              end
            end
          end
        end
        LOCKED: begin
          // Reaching the limit takes effect one cycle later, and that cycle forwards nothing.
          if (err_full) begin
            state_q <= HUNT;
          end else if (dec_fire) begin
            out_val_q <= 1'b1;
            out_dat_q <= bus.dec_dout_dat;
            out_k_q   <= bus.dec_dout_k;
            out_err_q <= dec_err;
            if (dec_err) begin
              err_cnt_q  <= err_cnt_q + 1'b1;
              good_cnt_q <= '0;
            end else if (good_cnt_q == GOOD_LAST) begin
              good_cnt_q <= '0;
              if (err_cnt_q != '0) begin
                err_cnt_q <= err_cnt_q - 1'b1;
              end
            end else begin
              good_cnt_q <= good_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign bus.dec_din_ena = din_ena_q;
  assign bus.dec_din_dat = din_dat_q;
  assign bus.dec_din_rd  = rd_q;
  assign bus.bitslip     = bitslip_q;
  assign bus.out_val     = out_val_q;
  assign bus.out_dat     = out_dat_q;
  assign bus.out_k       = out_k_q;
  assign bus.out_err     = out_err_q;
  assign bus.link_locked = (state_q == LOCKED);
  assign bus.link_state  = state_q;
  assign bus.err_cnt     = err_cnt_q;
endmodule
